// File: rtl/hack_mem_arbiter.sv
// Shares the Hack data memory between the CPU data port and a screen-scanout reader.
// Optional grant/conflict statistics counters are enabled with `define ARB_STATS_EN.
module hack_mem_arbiter #(
  parameter int                ADDR_W       = 15,
  parameter int                DATA_W       = 16,
  parameter logic [ADDR_W-1:0] SCREEN_BASE  = 15'h4000,
  parameter logic [ADDR_W-1:0] KBD_ADDR     = 15'h6000,
  parameter int                STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              scan_req,
  input  logic [12:0]       scan_offset,
  output logic              scan_gnt,
  output logic [DATA_W-1:0] scan_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_cpu_grants,
  output logic [15:0]       stat_scan_grants,
  output logic [15:0]       stat_conflicts
`endif
);

  localparam int STREAK_W = (STARVE_LIMIT < 8) ? 3 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  logic                cmd_valid;
  logic                cmd_scan;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [STREAK_W-1:0] scan_streak;

  logic              cpu_win;
  logic              scan_win;
  logic [ADDR_W-1:0] scan_addr;
  logic              active;
  logic              blocked;

  // The CPU only loses a conflict while the scan streak is below the limit.
  always_comb begin
    cpu_win   = cpu_req & (~scan_req | (scan_streak == LIMIT));
    scan_win  = scan_req & ~cpu_win;
    scan_addr = SCREEN_BASE + ADDR_W'(scan_offset);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid   <= 1'b0;
      cmd_scan    <= 1'b0;
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      scan_streak <= '0;
    end else begin
      cmd_valid <= cpu_req | scan_req;
      cmd_scan  <= scan_win;
      cmd_we    <= cpu_win & cpu_we;
      cmd_addr  <= cpu_win ? cpu_addr : scan_addr;
      cmd_wdata <= cpu_win ? cpu_wdata : '0;
      if (!cpu_req || cpu_win)
        scan_streak <= '0;
      else if (scan_win && scan_streak != LIMIT)
        scan_streak <= scan_streak + 1'b1;
    end
  end

  // Gating with reset keeps a latched write from committing during the reset cycle.
  always_comb begin
    active      = cmd_valid & ~reset;
    blocked     = cmd_we & (cmd_addr >= KBD_ADDR);
    cpu_gnt     = active & ~cmd_scan;
    scan_gnt    = active & cmd_scan;
    cpu_err     = cpu_gnt & blocked;
    mem_load    = active & cmd_we & ~blocked;
    mem_address = active ? cmd_addr : '0;
    mem_in      = active ? cmd_wdata : '0;
    cpu_rdata   = mem_out;
    scan_rdata  = mem_out;
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cpu_grants  <= '0;
      stat_scan_grants <= '0;
      stat_conflicts   <= '0;
    end else begin
      if (cpu_gnt && stat_cpu_grants != 16'hFFFF)
        stat_cpu_grants <= stat_cpu_grants + 16'd1;
      if (scan_gnt && stat_scan_grants != 16'hFFFF)
        stat_scan_grants <= stat_scan_grants + 16'd1;
      if (cpu_req && scan_req && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule
